// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between the CPU core and the debug loader.
// Each transaction is accepted in IDLE, issued for one cycle, then (reads only) waits MEM_LAT and responds.
module mem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Handshake: a request transfers on a cycle where req and ready are both high.
    // ready is only ever raised in IDLE, and the requester holds its fields until then.
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

    state_t     state;
    logic       last_dbg;
    logic       owner_dbg;
    logic [2:0] cnt;
    logic       gnt_cpu;
    logic       gnt_dbg;

    // On a tie the port that was not served last wins; last_dbg resets high so the CPU goes first.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_dbg = 1'b0;
        if (state == IDLE && !rst) begin
            if (cpu_req && (!dbg_req || last_dbg)) begin
                gnt_cpu = 1'b1;
            end else if (dbg_req) begin
                gnt_dbg = 1'b1;
            end
        end
    end

    assign cpu_ready = gnt_cpu;
    assign dbg_ready = gnt_dbg;
    assign busy      = (state != IDLE);

    // mem_addr/mem_wdata double as the holding registers and keep the last issued values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_dbg   <= 1'b1;
            owner_dbg  <= 1'b0;
            cnt        <= 3'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_cpu || gnt_dbg) begin
                        owner_dbg <= gnt_dbg;
                        last_dbg  <= gnt_dbg;
                        mem_en    <= 1'b1;
                        mem_we    <= gnt_dbg ? dbg_we    : cpu_we;
                        mem_addr  <= gnt_dbg ? dbg_addr  : cpu_addr;
                        mem_wdata <= gnt_dbg ? dbg_wdata : cpu_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (mem_we) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= LAT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        if (owner_dbg) begin
                            dbg_rdata  <= mem_rdata;
                            dbg_rvalid <= 1'b1;
                        end else begin
                            cpu_rdata  <= mem_rdata;
                            cpu_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT 1 and 7) each driven by its own requesters and
// checked every cycle against a timeline model of accept/issue/response events.
module tb_mem_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              cpu_req[2], cpu_we[2], dbg_req[2], dbg_we[2];
    logic [ADDR_W-1:0] cpu_addr[2], dbg_addr[2], mem_addr[2];
    logic [DATA_W-1:0] cpu_wdata[2], dbg_wdata[2], cpu_rdata[2], dbg_rdata[2];
    logic [DATA_W-1:0] mem_wdata[2], mem_rdata[2];
    logic              cpu_ready[2], dbg_ready[2], cpu_rvalid[2], dbg_rvalid[2];
    logic              mem_en[2], mem_we[2], busy[2];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 7;
    endfunction

    function automatic logic [DATA_W-1:0] init_word(input int k);
        return 32'hC0DE_0000 + 32'(k * 17);
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(g == 0 ? 1 : 7)) u_dut (
            .clk(clk), .rst(rst),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]), .cpu_ready(cpu_ready[g]),
            .cpu_rvalid(cpu_rvalid[g]), .cpu_rdata(cpu_rdata[g]),
            .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]),
            .dbg_wdata(dbg_wdata[g]), .dbg_ready(dbg_ready[g]),
            .dbg_rvalid(dbg_rvalid[g]), .dbg_rdata(dbg_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );

        // Memory device: read data is only correct during the cycle MEM_LAT after mem_en.
        logic [DATA_W-1:0] dev_mem[16];
        logic [DATA_W-1:0] rd_val;
        int                rd_delay;
        always @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < 16; k++) dev_mem[k] <= init_word(k);
                rd_val   <= '0;
                rd_delay <= 0;
            end else begin
                if (mem_en[g] && mem_we[g]) dev_mem[mem_addr[g][5:2]] <= mem_wdata[g];
                if (mem_en[g] && !mem_we[g]) begin
                    rd_val   <= dev_mem[mem_addr[g][5:2]];
                    rd_delay <= lat_of(g);
                end else if (rd_delay > 0) begin
                    rd_delay <= rd_delay - 1;
                end
            end
        end
        assign mem_rdata[g] = (rd_delay == 1) ? rd_val : ~rd_val;
    end

    // Requesters: index [instance][port], port 0 = CPU, 1 = DBG.
    bit                r_act[2][2];
    logic              r_we[2][2];
    logic [ADDR_W-1:0] r_addr[2][2];
    logic [DATA_W-1:0] r_wdata[2][2];

    // Reference model state (cycle timestamps of the next events).
    int                cyc;
    int                idle_at[2], busy_from[2], iss_cyc[2], rv_cyc[2], rv_port[2];
    bit                last_dbg[2];
    logic              iss_we[2];
    logic [ADDR_W-1:0] iss_addr[2];
    logic [DATA_W-1:0] iss_wdata[2];
    logic [DATA_W-1:0] ref_mem[2][16];
    logic [DATA_W-1:0] exp_q[2][$];
    logic              e_en[2], e_we[2], e_rv[2][2];
    logic [ADDR_W-1:0] e_maddr[2];
    logic [DATA_W-1:0] e_mwdata[2];
    logic [DATA_W-1:0] e_rdata[2][2];
    int                last_hs[2][2], last_rv_obs[2][2];
    int                gnt_n[2], gnt_port[2][8], gnt_cyc[2][8];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic arm(input int i, input int p, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
        r_act[i][p]   = 1'b1;
        r_we[i][p]    = we;
        r_addr[i][p]  = a;
        r_wdata[i][p] = d;
    endtask

    task automatic clear_grants();
        for (int i = 0; i < 2; i++) begin
            gnt_n[i] = 0;
            for (int k = 0; k < 8; k++) begin
                gnt_port[i][k] = -1;
                gnt_cyc[i][k]  = -1;
            end
        end
    endtask

    task automatic drive(input bit r);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                cpu_req[i] = 1'($urandom_range(0, 1)); cpu_we[i] = 1'($urandom_range(0, 1));
                dbg_req[i] = 1'($urandom_range(0, 1)); dbg_we[i] = 1'($urandom_range(0, 1));
                cpu_addr[i] = $urandom(); cpu_wdata[i] = $urandom();
                dbg_addr[i] = $urandom(); dbg_wdata[i] = $urandom();
            end else begin
                cpu_req[i] = r_act[i][0]; cpu_we[i] = r_we[i][0];
                cpu_addr[i] = r_addr[i][0]; cpu_wdata[i] = r_wdata[i][0];
                dbg_req[i] = r_act[i][1]; dbg_we[i] = r_we[i][1];
                dbg_addr[i] = r_addr[i][1]; dbg_wdata[i] = r_wdata[i][1];
            end
        end
    endtask

    task automatic model_cycle(input int i, input bit r);
        logic  e_busy;
        int    win;
        string s;
        e_busy = 1'b0;
        win    = -1;
        e_en[i] = 1'b0; e_we[i] = 1'b0; e_rv[i][0] = 1'b0; e_rv[i][1] = 1'b0;
        if (r) begin
            idle_at[i] = 0; busy_from[i] = 0; iss_cyc[i] = -1; rv_cyc[i] = -1;
            last_dbg[i] = 1'b1;
            e_maddr[i] = '0; e_mwdata[i] = '0; e_rdata[i][0] = '0; e_rdata[i][1] = '0;
            exp_q[i].delete();
            for (int k = 0; k < 16; k++) ref_mem[i][k] = init_word(k);
        end else begin
            if (cyc == iss_cyc[i]) begin
                e_en[i] = 1'b1; e_we[i] = iss_we[i];
                e_maddr[i] = iss_addr[i]; e_mwdata[i] = iss_wdata[i];
                if (iss_we[i]) ref_mem[i][iss_addr[i][5:2]] = iss_wdata[i];
                else exp_q[i].push_back(ref_mem[i][iss_addr[i][5:2]]);
            end
            if (cyc == rv_cyc[i]) begin
                e_rv[i][rv_port[i]] = 1'b1;
                if (exp_q[i].size() > 0) e_rdata[i][rv_port[i]] = exp_q[i].pop_front();
            end
            e_busy = (cyc >= busy_from[i]) && (cyc < idle_at[i]);
            if (!e_busy) begin
                if (r_act[i][0] && r_act[i][1]) win = last_dbg[i] ? 0 : 1;
                else if (r_act[i][0]) win = 0;
                else if (r_act[i][1]) win = 1;
            end
        end
        s = $sformatf("i%0d c%0d", i, cyc);
        chk({s, " cpu_ready"},  cpu_ready[i],  (win == 0));
        chk({s, " dbg_ready"},  dbg_ready[i],  (win == 1));
        chk({s, " cpu_rvalid"}, cpu_rvalid[i], e_rv[i][0]);
        chk({s, " dbg_rvalid"}, dbg_rvalid[i], e_rv[i][1]);
        chk({s, " cpu_rdata"},  cpu_rdata[i],  e_rdata[i][0]);
        chk({s, " dbg_rdata"},  dbg_rdata[i],  e_rdata[i][1]);
        chk({s, " mem_en"},     mem_en[i],     e_en[i]);
        chk({s, " mem_we"},     mem_we[i],     e_we[i]);
        chk({s, " mem_addr"},   mem_addr[i],   e_maddr[i]);
        chk({s, " mem_wdata"},  mem_wdata[i],  e_mwdata[i]);
        chk({s, " busy"},       busy[i],       e_busy);
        if (cpu_rvalid[i]) last_rv_obs[i][0] = cyc;
        if (dbg_rvalid[i]) last_rv_obs[i][1] = cyc;
        if (win >= 0) begin
            last_dbg[i]  = (win == 1);
            iss_cyc[i]   = cyc + 1;
            busy_from[i] = cyc + 1;
            iss_we[i]    = r_we[i][win];
            iss_addr[i]  = r_addr[i][win];
            iss_wdata[i] = r_wdata[i][win];
            if (r_we[i][win]) begin
                idle_at[i] = cyc + 2;
            end else begin
                idle_at[i] = cyc + 3 + lat_of(i);
                rv_cyc[i]  = cyc + 2 + lat_of(i);
                rv_port[i] = win;
            end
            last_hs[i][win] = cyc;
            if (gnt_n[i] < 8) begin
                gnt_port[i][gnt_n[i]] = win;
                gnt_cyc[i][gnt_n[i]]  = cyc;
                gnt_n[i]++;
            end
            r_act[i][win] = 1'b0;
        end
    endtask

    // mode 0: directed only, 1: every idle requester re-arms a read, 2: random traffic.
    task automatic step(input bit r, input int mode);
        rst = r;
        drive(r);
        @(negedge clk);
        for (int i = 0; i < 2; i++) model_cycle(i, r);
        if (!r) begin
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    if (!r_act[i][p]) begin
                        if (mode == 1) arm(i, p, 1'b0, rand_addr(), $urandom());
                        else if (mode == 2 && $urandom_range(0, 2) == 0)
                            arm(i, p, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n, input int mode);
        repeat (n) step(1'b0, mode);
    endtask

    task automatic reset_pulse(input int n);
        for (int i = 0; i < 2; i++) begin
            r_act[i][0] = 1'b0;
            r_act[i][1] = 1'b0;
        end
        repeat (n) step(1'b1, 0);
        run(3, 0);
    endtask

    initial begin
        int rel;
        rst = 1'b1;
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                r_act[i][p] = 1'b0; r_we[i][p] = 1'b0; r_addr[i][p] = '0; r_wdata[i][p] = '0;
                last_hs[i][p] = -1000; last_rv_obs[i][p] = -1000;
            end
        end
        clear_grants();
        drive(1'b1);
        @(posedge clk);
        #1;

        reset_pulse(2);
        run(3, 0);

        // CPU write of DEADBEEF to 0x10
        for (int i = 0; i < 2; i++) arm(i, 0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        run(4, 0);
        for (int i = 0; i < 2; i++) chk($sformatf("i%0d wr_grant_count", i), gnt_n[i], 1);

        // CPU read back of 0x10
        for (int i = 0; i < 2; i++) arm(i, 0, 1'b0, 32'h10, $urandom());
        run(12, 0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("i%0d cpu_rd_latency", i), last_rv_obs[i][0] - last_hs[i][0], 2 + lat_of(i));
            chk($sformatf("i%0d cpu_rd_value", i), cpu_rdata[i], 32'hDEAD_BEEF);
            chk($sformatf("i%0d dbg_rdata_untouched", i), dbg_rdata[i], 32'h0);
        end

        // DBG read of 0x10 (instance 1 gives the MEM_LAT=7 latency)
        for (int i = 0; i < 2; i++) arm(i, 1, 1'b0, 32'h10, $urandom());
        run(12, 0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("i%0d dbg_rd_latency", i), last_rv_obs[i][1] - last_hs[i][1], 2 + lat_of(i));
            chk($sformatf("i%0d dbg_rd_value", i), dbg_rdata[i], 32'hDEAD_BEEF);
        end

        // Continuous contention from reset
        reset_pulse(1);
        clear_grants();
        for (int i = 0; i < 2; i++) begin
            arm(i, 0, 1'b0, 32'h20, $urandom());
            arm(i, 1, 1'b0, 32'h24, $urandom());
        end
        run(45, 1);
        run(35, 0);
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("i%0d gnt_order_%0d", i, k), gnt_port[i][k], k % 2);
            for (int k = 0; k < 3; k++)
                chk($sformatf("i%0d gnt_spacing_%0d", i, k), gnt_cyc[i][k + 1] - gnt_cyc[i][k],
                    3 + lat_of(i));
        end

        // Reset two cycles after a CPU read handshake, then an immediate DBG request
        for (int i = 0; i < 2; i++) arm(i, 0, 1'b0, 32'h14, 32'h0);
        run(2, 0);
        step(1'b1, 0);
        for (int i = 0; i < 2; i++) arm(i, 1, 1'b0, 32'h10, 32'h0);
        rel = cyc;
        run(12, 0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("i%0d dbg_hs_after_rst", i), last_hs[i][1], rel);
            chk($sformatf("i%0d cpu_rdata_after_rst", i), cpu_rdata[i], 32'h0);
        end

        // Random traffic, a reset in the middle of it, more traffic, drain
        run(200, 2);
        reset_pulse(3);
        run(300, 2);
        run(35, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified instruction/data memory of the multi-cycle CPU between the CPU core and a debug/program-loader port. Each requester uses a valid/ready request handshake plus a one-cycle read-response pulse. The arbiter sequences every memory transaction: accept, issue, latency wait, response. It also guarantees round-robin fairness when both requesters contend. It sits between the CPU top level, the debug loader and the memory macro.

## Interface

Parameters:

- DATA_W, 32, data width of the memory and both ports
- ADDR_W, 32, address width
- MEM_LAT, 1, memory read latency in cycles; legal range 1..7

Ports (clock and reset first):

- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock, rising edge
  - rst  in  1  asynchronous, active-high reset
- CPU request channel:
  - cpu_req  in  1  CPU request valid
  - cpu_we  in  1  CPU write (1) / read (0)
  - cpu_addr  in  ADDR_W  CPU address
  - cpu_wdata  in  DATA_W  CPU write data
  - cpu_ready  out  1  CPU request accepted this cycle
- CPU response channel:
  - cpu_rvalid  out  1  one-cycle pulse, CPU read data valid
  - cpu_rdata  out  DATA_W  CPU read data
- Debug port, same meanings as the CPU ports:
  - dbg_req  in  1
  - dbg_we  in  1
  - dbg_addr  in  ADDR_W
  - dbg_wdata  in  DATA_W
  - dbg_ready  out  1
  - dbg_rvalid  out  1
  - dbg_rdata  out  DATA_W
- Memory side:
  - mem_en  out  1  memory access strobe
  - mem_we  out  1  memory write enable
  - mem_addr  out  ADDR_W  memory address
  - mem_wdata  out  DATA_W  memory write data
  - mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  high whenever the state is not IDLE

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Arbitrate among the active requests.
  - If exactly one request is high, it wins.
  - If both are high, the requester not granted last wins.
  - The winner's ready is asserted combinationally in this cycle. A handshake occurs when req and ready are both high.
  - On the handshake, latch we/addr/wdata and the owner into holding registers, update last_gnt, and go to ISSUE.
  - With no request, remain in IDLE.
- **ISSUE:** drive mem_en=1, plus mem_we/mem_addr/mem_wdata from the holding registers.
  - Write: next state IDLE.
  - Read: load the latency counter with MEM_LAT, next state WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture mem_rdata into the owner's rdata register and go to RESP.
- **RESP:** pulse the owner's rvalid for exactly one cycle, then go to IDLE.
- ready is never asserted outside IDLE. Requests made while busy stay pending; the requester holds req and the request fields until ready.
- Requesters may change or drop req freely after the handshake; the holding registers decouple them from the memory.
- cpu_rdata and dbg_rdata hold their value until the next read response to the same port.
- The non-owner's rvalid and rdata never change.
- mem_en=0 outside ISSUE. While mem_en=0, mem_we=0, and mem_addr/mem_wdata hold the last issued values.
- last_gnt resets to DBG, so the first tie goes to the CPU.
- Write data passes through unmodified. Addresses are not translated or checked.

## Timing

- Reset (asynchronous, any state):
  - State returns to IDLE.
  - All outputs go to 0: ready, rvalid, rdata, mem_*, busy.
  - The counter clears to 0; last_gnt goes to DBG.
  - An in-flight transaction is dropped with no rvalid.
  - Requests are ignored while rst=1.
- Handshake at cycle T is followed by ISSUE at T+1.
- Write: the memory writes at T+1. IDLE returns at T+2, so the next handshake is possible at T+2. Occupancy is 2 cycles.
- Read:
  - WAIT spans T+2 .. T+1+MEM_LAT.
  - rdata is captured at the end of T+1+MEM_LAT.
  - rvalid is high at T+2+MEM_LAT.
  - IDLE returns at T+3+MEM_LAT, so occupancy is MEM_LAT+3 cycles.
- Under continuous contention, grants strictly alternate CPU, DBG, CPU, ..., so neither port waits for more than one foreign transaction.
- A request that arrives in RESP is accepted in the following IDLE cycle, never in RESP.
- The counter is 3 bits; MEM_LAT=7 must neither wrap nor alias.

## Test plan

- **Reset:** assert rst mid-simulation with random inputs. All outputs must read 0 and busy=0. After release with cpu_req=0 and dbg_req=0, mem_en must stay 0.
- **CPU write:** CPU writes addr 0x0000_0010, data 0xDEAD_BEEF.
  - cpu_ready=1 at T.
  - mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF at T+1.
  - busy=0 at T+2.
- **CPU read, MEM_LAT=1:** CPU reads addr 0x10, with the memory model returning 0xDEADBEEF. cpu_rvalid must pulse at T+3 with cpu_rdata=0xDEADBEEF; dbg_rvalid must stay 0.
- **Simultaneous requests from reset:** cpu_req and dbg_req both held high with reads.
  - Grant order must be CPU, DBG, CPU, DBG.
  - With MEM_LAT=1, handshakes occur every 4 cycles.
  - Each rdata routes only to its owner.
- **MEM_LAT=7 read by DBG:** dbg_rvalid must rise exactly 9 cycles after dbg_ready. No early pulse, and no counter wrap.
- **Reset during WAIT:** start a CPU read, assert rst at T+2.
  - There must be no cpu_rvalid, and cpu_rdata must be 0.
  - After release, a fresh DBG request gets dbg_ready in the first IDLE cycle.
